// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, port-select codes and parameter defaults.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int TIMEOUT_DEFAULT     = 255;
    localparam int MAX_D_BURST_DEFAULT = 4;

    function automatic logic is_busy(input arb_state_e st);
        return (st == ST_BUSY_I) || (st == ST_BUSY_D);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Grant decision for the shared memory: data port first, but after
// MAX_D_BURST back-to-back data grants a waiting fetch gets its turn.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_BURST = MAX_D_BURST_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en_s,
    input  logic i_req_s,
    input  logic d_req_s,
    output logic grant_s,
    output logic grant_port_s
);

    localparam logic [3:0] MAX_C = 4'(MAX_D_BURST);

    logic [3:0] dcnt_q;
    logic [3:0] dcnt_d;

    // Grant selection and saturating count of consecutive data grants.
    always_comb begin
        grant_s      = 1'b0;
        grant_port_s = PORT_I;
        dcnt_d       = dcnt_q;
        if (arb_en_s) begin
            if (d_req_s && !(i_req_s && (dcnt_q == MAX_C))) begin
                grant_s      = 1'b1;
                grant_port_s = PORT_D;
                if (i_req_s) begin
                    if (dcnt_q != MAX_C) begin
                        dcnt_d = dcnt_q + 4'd1;
                    end else begin
                        dcnt_d = dcnt_q;
                    end
                end else begin
                    dcnt_d = 4'd0;
                end
            end else if (i_req_s) begin
                grant_s      = 1'b1;
                grant_port_s = PORT_I;
                dcnt_d       = 4'd0;
            end else begin
                dcnt_d = dcnt_q;
            end
        end else begin
            dcnt_d = dcnt_q;
        end
    end

    // Burst counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= 4'd0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports,
// one transaction at a time, with a per-access timeout and sticky ERR.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = MAX_D_BURST_DEFAULT,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_req,
    input  logic [ADDR_W-1:0] I_addr,
    output logic [DATA_W-1:0] I_rdata,
    output logic              I_valid,
    output logic              I_stall,
    input  logic              D_req,
    input  logic              D_we,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_wdata,
    output logic [DATA_W-1:0] D_rdata,
    output logic              D_valid,
    output logic              D_stall,
    output logic              M_req,
    output logic              M_we,
    output logic [ADDR_W-1:0] M_addr,
    output logic [DATA_W-1:0] M_wdata,
    input  logic              M_ack,
    input  logic [DATA_W-1:0] M_rdata,
    output logic              ERR
);

    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic       TIMEOUT_EN = (TIMEOUT != 0);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              grant_s;
    logic              grant_port_s;
    logic              timeout_s;

    arb_starve_ctr #(
        .MAX_D_BURST (MAX_D_BURST)
    ) u_starve (
        .clk          (CLK),
        .rst_n        (RESET),
        .arb_en_s     (state_q == ST_IDLE),
        .i_req_s      (I_req),
        .d_req_s      (D_req),
        .grant_s      (grant_s),
        .grant_port_s (grant_port_s)
    );

    assign timeout_s = TIMEOUT_EN && (wcnt_q == TIMEOUT_C);

    // Next-state, capture and completion logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wcnt_d    = wcnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    wcnt_d = 8'd0;
                    if (grant_port_s == PORT_D) begin
                        state_d = ST_BUSY_D;
                        addr_d  = D_addr;
                        we_d    = D_we;
                        wdata_d = D_wdata;
                    end else begin
                        state_d = ST_BUSY_I;
                        addr_d  = I_addr;
                        we_d    = 1'b0;
                        wdata_d = {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_I: begin
                wcnt_d = wcnt_q + 8'd1;
                // An ack in the timeout cycle still completes normally.
                if (M_ack) begin
                    i_rdata_d = M_rdata;
                    state_d   = ST_RESP_I;
                end else if (timeout_s) begin
                    err_d     = 1'b1;
                    i_rdata_d = {DATA_W{1'b0}};
                    state_d   = ST_RESP_I;
                end else begin
                    state_d = ST_BUSY_I;
                end
            end
            ST_BUSY_D: begin
                wcnt_d = wcnt_q + 8'd1;
                if (M_ack) begin
                    if (!we_q) begin
                        d_rdata_d = M_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    state_d = ST_RESP_D;
                end else if (timeout_s) begin
                    err_d     = 1'b1;
                    d_rdata_d = {DATA_W{1'b0}};
                    state_d   = ST_RESP_D;
                end else begin
                    state_d = ST_BUSY_D;
                end
            end
            ST_RESP_I: state_d = ST_IDLE;
            ST_RESP_D: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, capture and response registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            addr_q    <= {ADDR_W{1'b0}};
            we_q      <= 1'b0;
            wdata_q   <= {DATA_W{1'b0}};
            wcnt_q    <= 8'd0;
            i_rdata_q <= {DATA_W{1'b0}};
            d_rdata_q <= {DATA_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wcnt_q    <= wcnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign M_req   = is_busy(state_q);
    assign M_we    = we_q && is_busy(state_q);
    assign M_addr  = addr_q;
    assign M_wdata = wdata_q;
    assign I_valid = (state_q == ST_RESP_I);
    assign D_valid = (state_q == ST_RESP_D);
    assign I_rdata = i_rdata_q;
    assign D_rdata = d_rdata_q;
    assign I_stall = I_req && !I_valid;
    assign D_stall = D_req && !D_valid;
    assign ERR     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge,
// outputs are checked on the falling edge against hand-computed values.
module tb_mem_port_arbiter;

    logic        CLK;
    logic        RESET;
    logic        I_req;
    logic [31:0] I_addr;
    logic [31:0] I_rdata;
    logic        I_valid;
    logic        I_stall;
    logic        D_req;
    logic        D_we;
    logic [31:0] D_addr;
    logic [31:0] D_wdata;
    logic [31:0] D_rdata;
    logic        D_valid;
    logic        D_stall;
    logic        M_req;
    logic        M_we;
    logic [31:0] M_addr;
    logic [31:0] M_wdata;
    logic        M_ack;
    logic [31:0] M_rdata;
    logic        ERR;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_BURST (4),
        .TIMEOUT     (3)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .I_req   (I_req),
        .I_addr  (I_addr),
        .I_rdata (I_rdata),
        .I_valid (I_valid),
        .I_stall (I_stall),
        .D_req   (D_req),
        .D_we    (D_we),
        .D_addr  (D_addr),
        .D_wdata (D_wdata),
        .D_rdata (D_rdata),
        .D_valid (D_valid),
        .D_stall (D_stall),
        .M_req   (M_req),
        .M_we    (M_we),
        .M_addr  (M_addr),
        .M_wdata (M_wdata),
        .M_ack   (M_ack),
        .M_rdata (M_rdata),
        .ERR     (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Grant order under sustained D and I requests with a burst limit of 4.
    bit exp_is_d [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int n_busy;
        RESET   = 1'b0;
        I_req   = 1'b0;
        I_addr  = 32'h0;
        D_req   = 1'b0;
        D_we    = 1'b0;
        D_addr  = 32'h0;
        D_wdata = 32'h0;
        M_ack   = 1'b0;
        M_rdata = 32'h0;

        repeat (2) @(negedge CLK);
        chk("rst_m_req",   {31'd0, M_req},   32'd0);
        chk("rst_m_we",    {31'd0, M_we},    32'd0);
        chk("rst_m_addr",  M_addr,           32'd0);
        chk("rst_i_valid", {31'd0, I_valid}, 32'd0);
        chk("rst_d_valid", {31'd0, D_valid}, 32'd0);
        chk("rst_err",     {31'd0, ERR},     32'd0);
        chk("rst_i_rdata", I_rdata,          32'd0);
        chk("rst_d_rdata", D_rdata,          32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        // Single fetch, zero-wait memory.
        I_req  = 1'b1;
        I_addr = 32'h40;
        #1;
        chk("f1_i_stall_req", {31'd0, I_stall}, 32'd1);
        @(negedge CLK);
        chk("f1_m_req",  {31'd0, M_req}, 32'd1);
        chk("f1_m_addr", M_addr,         32'h40);
        chk("f1_m_we",   {31'd0, M_we},  32'd0);
        M_ack   = 1'b1;
        M_rdata = 32'h8C220004;
        @(negedge CLK);
        chk("f1_i_valid", {31'd0, I_valid}, 32'd1);
        chk("f1_i_rdata", I_rdata,          32'h8C220004);
        chk("f1_m_req_resp", {31'd0, M_req}, 32'd0);
        chk("f1_i_stall_valid", {31'd0, I_stall}, 32'd0);
        M_ack = 1'b0;
        I_req = 1'b0;
        @(negedge CLK);
        chk("f1_i_valid_idle", {31'd0, I_valid}, 32'd0);
        chk("f1_m_req_idle",   {31'd0, M_req},   32'd0);
        chk("f1_i_rdata_hold", I_rdata,          32'h8C220004);

        // Simultaneous requests: store wins, fetch follows.
        I_req   = 1'b1;
        I_addr  = 32'h44;
        D_req   = 1'b1;
        D_we    = 1'b1;
        D_addr  = 32'h100;
        D_wdata = 32'h1234;
        #1;
        chk("sim_i_stall0", {31'd0, I_stall}, 32'd1);
        chk("sim_d_stall0", {31'd0, D_stall}, 32'd1);
        @(negedge CLK);
        chk("sim_m_we",    {31'd0, M_we},    32'd1);
        chk("sim_m_addr",  M_addr,           32'h100);
        chk("sim_m_wdata", M_wdata,          32'h1234);
        chk("sim_i_stall1", {31'd0, I_stall}, 32'd1);
        M_ack   = 1'b1;
        M_rdata = 32'hDEADBEEF;
        @(negedge CLK);
        chk("sim_d_valid",  {31'd0, D_valid}, 32'd1);
        chk("sim_d_rdata_store", D_rdata,     32'd0);
        chk("sim_i_stall2", {31'd0, I_stall}, 32'd1);
        D_req = 1'b0;
        M_ack = 1'b0;
        @(negedge CLK);
        chk("sim_m_req_idle", {31'd0, M_req},   32'd0);
        chk("sim_i_stall3",   {31'd0, I_stall}, 32'd1);
        @(negedge CLK);
        chk("sim_f_m_req",  {31'd0, M_req}, 32'd1);
        chk("sim_f_m_addr", M_addr,         32'h44);
        chk("sim_f_m_we",   {31'd0, M_we},  32'd0);
        M_ack   = 1'b1;
        M_rdata = 32'hAAAA0001;
        @(negedge CLK);
        chk("sim_f_i_valid", {31'd0, I_valid}, 32'd1);
        chk("sim_f_i_rdata", I_rdata,          32'hAAAA0001);
        I_req = 1'b0;
        M_ack = 1'b0;
        @(negedge CLK);

        // Starvation limit: D,D,D,D,I,D,D,D,D,I,D.
        I_req  = 1'b1;
        I_addr = 32'h80;
        D_req  = 1'b1;
        D_we   = 1'b0;
        D_addr = 32'h200;
        for (int g = 0; g < 11; g++) begin
            @(negedge CLK);
            chk($sformatf("starve_addr_%0d", g), M_addr, exp_is_d[g] ? 32'h200 : 32'h80);
            M_ack   = 1'b1;
            M_rdata = 32'h100 + 32'(g);
            @(negedge CLK);
            if (exp_is_d[g]) begin
                chk($sformatf("starve_d_valid_%0d", g), {31'd0, D_valid}, 32'd1);
                chk($sformatf("starve_d_rdata_%0d", g), D_rdata, 32'h100 + 32'(g));
            end else begin
                chk($sformatf("starve_i_valid_%0d", g), {31'd0, I_valid}, 32'd1);
                chk($sformatf("starve_i_rdata_%0d", g), I_rdata, 32'h100 + 32'(g));
            end
            M_ack = 1'b0;
            @(negedge CLK);
        end

        // Ack arriving in the timeout cycle (wcnt==3) completes normally.
        I_req  = 1'b0;
        D_addr = 32'h310;
        repeat (3) begin
            @(negedge CLK);
            chk("col_m_req", {31'd0, M_req}, 32'd1);
        end
        @(negedge CLK);
        chk("col_m_req_last", {31'd0, M_req}, 32'd1);
        M_ack   = 1'b1;
        M_rdata = 32'h5A5A5A5A;
        @(negedge CLK);
        chk("col_d_valid", {31'd0, D_valid}, 32'd1);
        chk("col_d_rdata", D_rdata,          32'h5A5A5A5A);
        chk("col_err",     {31'd0, ERR},     32'd0);
        M_ack  = 1'b0;
        D_addr = 32'h320;
        @(negedge CLK);
        chk("to_err_before", {31'd0, ERR}, 32'd0);

        // Timeout: no ack, M_req high for exactly 4 cycles.
        n_busy = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (M_req) begin
                n_busy++;
            end else begin
                break;
            end
        end
        chk("to_busy_cycles", 32'(n_busy),        32'd4);
        chk("to_d_valid",     {31'd0, D_valid},   32'd1);
        chk("to_d_rdata",     D_rdata,            32'd0);
        chk("to_err",         {31'd0, ERR},       32'd1);
        D_req = 1'b0;
        @(negedge CLK);
        I_req  = 1'b1;
        I_addr = 32'h84;
        @(negedge CLK);
        M_ack   = 1'b1;
        M_rdata = 32'h13579BDF;
        @(negedge CLK);
        chk("post_to_i_valid", {31'd0, I_valid}, 32'd1);
        chk("post_to_i_rdata", I_rdata,          32'h13579BDF);
        chk("post_to_err",     {31'd0, ERR},     32'd1);
        I_req = 1'b0;
        M_ack = 1'b0;
        @(negedge CLK);

        // Asynchronous reset in the middle of a store.
        D_req   = 1'b1;
        D_we    = 1'b1;
        D_addr  = 32'h400;
        D_wdata = 32'h77;
        @(negedge CLK);
        chk("rm_m_req_busy", {31'd0, M_req}, 32'd1);
        #2;
        RESET  = 1'b0;
        D_req  = 1'b0;
        I_req  = 1'b1;
        I_addr = 32'h90;
        #1;
        chk("rm_m_req",   {31'd0, M_req},   32'd0);
        chk("rm_d_valid", {31'd0, D_valid}, 32'd0);
        chk("rm_m_we",    {31'd0, M_we},    32'd0);
        chk("rm_err",     {31'd0, ERR},     32'd0);
        @(negedge CLK);
        chk("rm_d_valid_hold", {31'd0, D_valid}, 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rm_f_m_req",   {31'd0, M_req},   32'd1);
        chk("rm_f_m_addr",  M_addr,           32'h90);
        chk("rm_f_d_valid", {31'd0, D_valid}, 32'd0);
        M_ack   = 1'b1;
        M_rdata = 32'h2468ACE0;
        @(negedge CLK);
        chk("rm_f_i_valid", {31'd0, I_valid}, 32'd1);
        chk("rm_f_i_rdata", I_rdata,          32'h2468ACE0);
        chk("rm_f_d_valid2", {31'd0, D_valid}, 32'd0);
        I_req = 1'b0;
        M_ack = 1'b0;
        @(negedge CLK);
        chk("rm_idle_m_req", {31'd0, M_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
